// File: rtl/ram_cmd_seq.sv
// Command sequencer in front of the RAM controller: queues write/read commands,
// issues each as a one-cycle en pulse, and returns one checked response per command.
module ram_cmd_seq #(
  parameter int p_mem_size   = 8,
  parameter int p_fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [1:0]                    cmd_op,
  input  logic [p_mem_size-1:0]         cmd_addr,
  input  logic [31:0]                   cmd_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [31:0]                   rsp_data,
  output logic [3:0]                    rsp_sign,
  output logic                          rsp_err,
  output logic [$clog2(p_fifo_depth):0] fifo_count,
  output logic                          en,
  output logic                          we,
  output logic                          re,
  output logic [1:0]                    op_code,
  output logic [p_mem_size-1:0]         addr,
  output logic [31:0]                   data_in,
  input  logic [31:0]                   data_out,
  input  logic [3:0]                    op_sign
);

  localparam int c_ptr_w = $clog2(p_fifo_depth);
  localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(p_fifo_depth);
  localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t state, state_nxt;

  logic                  fifo_write [p_fifo_depth];
  logic [1:0]            fifo_op    [p_fifo_depth];
  logic [p_mem_size-1:0] fifo_addr  [p_fifo_depth];
  logic [31:0]           fifo_data  [p_fifo_depth];
  logic [c_ptr_w-1:0]    wr_ptr, rd_ptr;

  logic       push, pop, capture, rsp_done, cur_write;
  logic [3:0] exp_sign;

  // Ready is held low while in reset so nothing is accepted before the controller is up.
  assign cmd_ready = rstN && (fifo_count < c_depth);
  assign push      = cmd_valid && cmd_ready;
  assign exp_sign  = {2'b00, op_code} + (cur_write ? 4'd1 : 4'd5);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write[wr_ptr] <= cmd_write;
      fifo_op[wr_ptr]    <= cmd_op;
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_data[wr_ptr]  <= cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + c_ptr_one;
      if (pop)  rd_ptr <= rd_ptr + c_ptr_one;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + c_cnt_one;
        2'b01:   fifo_count <= fifo_count - c_cnt_one;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_count != '0) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop      = (state == IDLE) && (fifo_count != '0);
    capture  = (state == CAPTURE);
    rsp_done = (state == RESP) && rsp_ready;
  end

  // Strobes are only set on the IDLE->ISSUE edge, so en lasts exactly the ISSUE cycle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      en        <= 1'b0;
      we        <= 1'b0;
      re        <= 1'b0;
      cur_write <= 1'b0;
      op_code   <= '0;
      addr      <= '0;
      data_in   <= '0;
    end else if (pop) begin
      en        <= 1'b1;
      we        <= fifo_write[rd_ptr];
      re        <= !fifo_write[rd_ptr];
      cur_write <= fifo_write[rd_ptr];
      op_code   <= fifo_op[rd_ptr];
      addr      <= fifo_addr[rd_ptr];
      data_in   <= fifo_data[rd_ptr];
    end else begin
      en <= 1'b0;
      we <= 1'b0;
      re <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_data  <= '0;
      rsp_sign  <= '0;
      rsp_err   <= 1'b0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_write <= cur_write;
      rsp_data  <= cur_write ? 32'd0 : data_out;
      rsp_sign  <= op_sign;
      rsp_err   <= (op_sign != exp_sign);
    end else if (rsp_done) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_cmd_seq.sv
// Bench for ram_cmd_seq: a stub RAM controller, a queue-based response model
// and directed scenarios with a few hand-computed literal checks.
module tb_ram_cmd_seq;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_addr = 8'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_write, rsp_err;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_sign;
  logic [2:0]  fifo_count;
  logic        en, we, re;
  logic [1:0]  op_code;
  logic [7:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out = 32'd0;
  logic [3:0]  op_sign = 4'd0;

  typedef struct {
    logic        write;
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    logic        write;
    logic [31:0] data;
    logic [3:0]  sign;
    logic        err;
  } rsp_t;

  cmd_t        issue_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] model_mem = 32'd0;
  logic [31:0] stub_mem = 32'd0;
  logic        prev_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  ram_cmd_seq #(.p_mem_size(8), .p_fifo_depth(4)) dut (
    .clk(clk), .rstN(rstN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_sign(rsp_sign), .rsp_err(rsp_err),
    .fifo_count(fifo_count), .en(en), .we(we), .re(re),
    .op_code(op_code), .addr(addr), .data_in(data_in),
    .data_out(data_out), .op_sign(op_sign)
  );

  always #5 clk = ~clk;

  // Controller stub: one stored word; address 8'hEE makes it report a bogus sign of 0.
  always @(posedge clk) begin
    if (en) begin
      if (we) stub_mem <= data_in;
      data_out <= we ? ~data_in : stub_mem;
      op_sign  <= (addr == 8'hEE) ? 4'h0 : ({2'b00, op_code} + (we ? 4'd1 : 4'd5));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [1:0] op, input logic [7:0] a,
                               input logic [31:0] d);
    int   waited;
    int   sign_i;
    cmd_t c;
    rsp_t r;
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL cmd_ready_timeout: got 0 expected 1 at %0t", $time);
      return;
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_op = op; cmd_addr = a; cmd_data = d;
    @(posedge clk);
    c.write = w; c.op = op; c.addr = a; c.data = d;
    issue_q.push_back(c);
    sign_i  = int'(op) + (w ? 1 : 5);
    r.write = w;
    r.sign  = (a == 8'hEE) ? 4'h0 : sign_i[3:0];
    r.err   = (int'(r.sign) != sign_i);
    r.data  = w ? 32'd0 : model_mem;
    if (w) model_mem = d;
    rsp_q.push_back(r);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input string name);
    int i;
    for (i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    checkOutput(name, {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic drainWait(input string name);
    int i;
    for (i = 0; i < 100 && (rsp_q.size() != 0 || rsp_valid); i++) begin
      @(posedge clk); #1;
    end
    checkOutput(name, rsp_q.size(), 32'd0);
  endtask

  // Every cycle: strobe sanity, issue order against the command queue, responses against the model.
  always @(negedge clk) begin
    if (rstN) begin
      if (en && prev_en) checkOutput("en_single_cycle", 32'd1, 32'd0);
      if (en) begin
        if (issue_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL stray_en: got en=1 expected no issue at %0t", $time);
        end else begin
          checkOutput("issue_we",   {31'd0, we}, {31'd0, issue_q[0].write});
          checkOutput("issue_re",   {31'd0, re}, {31'd0, !issue_q[0].write});
          checkOutput("issue_op",   {30'd0, op_code}, {30'd0, issue_q[0].op});
          checkOutput("issue_addr", {24'd0, addr}, {24'd0, issue_q[0].addr});
          checkOutput("issue_data", data_in, issue_q[0].data);
          void'(issue_q.pop_front());
        end
      end else begin
        checkOutput("idle_strobes", {30'd0, we, re}, 32'd0);
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL stray_rsp: got rsp_valid=1 expected no response at %0t", $time);
        end else begin
          checkOutput("rsp_write", {31'd0, rsp_write}, {31'd0, rsp_q[0].write});
          checkOutput("rsp_data",  rsp_data, rsp_q[0].data);
          checkOutput("rsp_sign",  {28'd0, rsp_sign}, {28'd0, rsp_q[0].sign});
          checkOutput("rsp_err",   {31'd0, rsp_err}, {31'd0, rsp_q[0].err});
          if (rsp_ready) void'(rsp_q.pop_front());
        end
      end
    end
    prev_en <= en;
  end

  initial begin
    #2 rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready",  {31'd0, cmd_ready}, 32'd0);
    checkOutput("reset_fifo_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("reset_en",         {31'd0, en}, 32'd0);
    checkOutput("reset_rsp_valid",  {31'd0, rsp_valid}, 32'd0);
    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset_ready", {31'd0, cmd_ready}, 32'd1);

    $display("[TB] single write latency");
    applyStimulus(1'b1, 2'd0, 8'h00, 32'hA5A5_0001);
    @(negedge clk);
    checkOutput("lat_en_T0", {31'd0, en}, 32'd0);
    @(negedge clk);
    checkOutput("lat_en_T1", {29'd0, en, we, re}, 32'b110);
    @(negedge clk);
    checkOutput("lat_en_T2", {30'd0, en, rsp_valid}, 32'd0);
    @(negedge clk);
    checkOutput("lat_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("lat_rsp_sign",  {28'd0, rsp_sign}, 32'd1);
    checkOutput("lat_rsp_data",  rsp_data, 32'd0);
    checkOutput("lat_rsp_err",   {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #1;
    drainWait("drain_t1");

    $display("[TB] write then read middle");
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 2'd1, 8'h10, 32'h0000_BEEF);
    applyStimulus(1'b0, 2'd1, 8'h10, 32'h0);
    waitRsp("t2_rsp1_valid");
    checkOutput("t2_write_sign", {28'd0, rsp_sign}, 32'd2);
    handshake();
    waitRsp("t2_rsp2_valid");
    checkOutput("t2_read_data", rsp_data, 32'h0000_BEEF);
    checkOutput("t2_read_sign", {28'd0, rsp_sign}, 32'd6);
    checkOutput("t2_read_err",  {31'd0, rsp_err}, 32'd0);
    rsp_ready = 1'b1;
    drainWait("drain_t2");

    $display("[TB] back-to-back fill");
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      applyStimulus(i[0], 2'(i), 8'(8'h20 + i), 32'hC0DE_0000 + i);
    checkOutput("full_count", {29'd0, fifo_count}, 32'd4);
    checkOutput("full_ready", {31'd0, cmd_ready}, 32'd0);
    rsp_ready = 1'b1;
    drainWait("drain_t3");
    checkOutput("empty_count", {29'd0, fifo_count}, 32'd0);

    $display("[TB] whole array write then end read");
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 2'd3, 8'h30, 32'h1234_5678);
    applyStimulus(1'b0, 2'd2, 8'h31, 32'h0);
    waitRsp("t4_rsp1_valid");
    checkOutput("t4_write_sign", {28'd0, rsp_sign}, 32'd4);
    handshake();
    waitRsp("t4_rsp2_valid");
    checkOutput("t4_read_sign", {28'd0, rsp_sign}, 32'd7);
    checkOutput("t4_read_data", rsp_data, 32'h1234_5678);
    rsp_ready = 1'b1;
    drainWait("drain_t4");

    $display("[TB] bad sign from controller");
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 2'd2, 8'hEE, 32'h0BAD_0BAD);
    waitRsp("t5_rsp_valid");
    checkOutput("t5_err",  {31'd0, rsp_err}, 32'd1);
    checkOutput("t5_sign", {28'd0, rsp_sign}, 32'd0);
    rsp_ready = 1'b1;
    drainWait("drain_t5");

    $display("[TB] reset during capture");
    applyStimulus(1'b0, 2'd1, 8'h40, 32'h0);
    applyStimulus(1'b0, 2'd1, 8'h41, 32'h0);
    applyStimulus(1'b0, 2'd1, 8'h42, 32'h0);
    rstN = 1'b0;
    #1;
    checkOutput("rst_en",        {31'd0, en}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_count",     {29'd0, fifo_count}, 32'd0);
    issue_q.delete();
    rsp_q.delete();
    @(posedge clk); #1;
    rstN = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("post_rst_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("post_rst_valid", {31'd0, rsp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_cmd_seq.md
Name: ram_cmd_seq

Overview:
- Upstream command sequencer for the RAM controller.
- Accepts write/read commands over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the controller as a single-cycle en pulse with we/re/op_code/addr/data_in.
- Captures data_out and op_sign after every command and returns one response per command over a valid/ready interface, flagging any op_sign mismatch.

Parameters:
- p_mem_size, 8: address width of addr/cmd_addr; must match the downstream controller.
- p_fifo_depth, 4: command FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstN  in  1  asynchronous active-low reset; shared with the controller.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_write  in  1  1=write, 0=read.
- cmd_op  in  2  0=begin, 1=middle, 2=end, 3=whole array.
- cmd_addr  in  p_mem_size  forwarded unchanged to addr.
- cmd_data  in  32  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  cmd_write of the completed command.
- rsp_data  out  32  data_out captured for reads; 0 for writes.
- rsp_sign  out  4  op_sign captured from the controller.
- rsp_err  out  1  rsp_sign differs from the expected sign.
- fifo_count  out  $clog2(p_fifo_depth)+1  current FIFO occupancy.
- en, we, re  out  1 each  controller strobes; registered.
- op_code  out  2  to controller; registered.
- addr  out  p_mem_size  to controller; registered.
- data_in  out  32  to controller; registered.
- data_out  in  32  from controller.
- op_sign  in  4  from controller.

Behaviour:
- Reset (rstN=0, asynchronous):
  - FIFO emptied; fifo_count=0; cmd_ready=0 while rstN=0, then 1.
  - FSM=IDLE.
  - en=we=re=0; op_code=0; addr=0; data_in=0.
  - rsp_valid=0; rsp_data=0; rsp_sign=0; rsp_write=0; rsp_err=0.
  - Reset mid-operation discards all queued and in-flight commands; no response is produced for them.
- FIFO:
  - Push when cmd_valid&&cmd_ready; pop when FSM leaves IDLE.
  - Push and pop in the same cycle leave the count unchanged.
  - cmd_ready = (fifo_count < p_fifo_depth), combinational from the count register.
  - When full, a pop in that cycle does not enable a push that cycle; ready rises the next cycle.
  - Pointers wrap modulo p_fifo_depth.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: if FIFO non-empty, load the head into the ram_* registers, pop, go to ISSUE. Otherwise stay.
  - ISSUE: en=1 for exactly this cycle; we=cmd_write, re=~cmd_write (never both 1). The controller samples at the end of this cycle. Go to CAPTURE.
  - CAPTURE: en=we=re=0. At the edge ending this cycle:
    - rsp_data <= data_out if read, else 0;
    - rsp_sign <= op_sign;
    - rsp_write <= stored write flag;
    - rsp_err <= (op_sign != expected), where expected = op_code+1 for writes and op_code+5 for reads (4-bit arithmetic, values 1..8);
    - rsp_valid <= 1. Go to RESP.
  - RESP: hold all rsp_* stable while rsp_valid&&!rsp_ready. On handshake: rsp_valid <= 0, go to IDLE.
- Latency: command accepted at edge T -> en high during cycle T+1..T+2 -> rsp_valid high from edge T+3.
- Throughput: at most one command per 4 cycles with rsp_ready held at 1; one command in flight at a time.
- Outside ISSUE, en=0, so the controller never performs stray operations. Address/data registers retain their last values.
- cmd_addr is forwarded as-is; the controller overrides it for ops 0-2.
- Responses return in command order; no reordering.

Test Plan:
- Reset, then push write op=0 data=32'hA5A5_0001 -> en/we pulse 1 cycle at T+1; rsp_valid at T+3 with rsp_sign=1, rsp_data=0, rsp_err=0.
- Write op=1 data=32'h0000_BEEF, then read op=1 -> second response: rsp_data=32'h0000_BEEF, rsp_sign=6, rsp_err=0.
- Push 5 commands back-to-back with rsp_ready=0 -> cmd_ready drops after the 4th is queued and 1 is in flight (fifo_count=4); raise rsp_ready -> all 5 responses in order; fifo_count returns to 0.
- Write op=3 data=32'h1234_5678, then read op=2 -> rsp_sign=4 then 7; read rsp_data=32'h1234_5678.
- Force op_sign=4'h0 on a write op=2 -> rsp_err=1, rsp_sign=0.
- Assert rstN low in CAPTURE with 2 commands queued -> en=0, rsp_valid=0, fifo_count=0 immediately; no responses after reset release.
